i2c_codec_config_seq: RTL
=========================

Name: i2c_codec_config_seq

Overview:
Configuration sequencer that sits directly upstream of the I2C byte-transfer controller. It generates the controller's divided I2C clock, walks a fixed table of audio-codec register writes, presents each 24-bit word {slave addr, reg addr/data} with a GO/END handshake, checks the three ACK bits and retries on NACK. It auto-starts after reset and can be re-triggered by START. Final status is reported on DONE/ERROR.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
I2C_FREQ, 20000, I2C SCL frequency in Hz (= controller clock frequency)
LUT_SIZE, 11, number of register writes in the table
MAX_RETRY, 3, extra attempts per word after the first NACK/timeout
SLAVE_ADDR, 8'h34, codec write address (R/W bit = 0)

Ports:
CLOCK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
START  in  1  one-CLOCK pulse, restarts the sequence from index 0 (honoured only in DONE/ERROR)
I2C_CTRL_CLK  out  1  divided clock feeding the controller's CLOCK input
I2C_DATA  out  24  {SLAVE_ADDR, reg[6:0], data[8:0]} to controller
GO  out  1  transfer request; low = controller held at count 0
END  in  1  controller transfer complete (synchronous to I2C_CTRL_CLK)
ACK  in  3  controller ACK bits; 3'b000 = all acknowledged
BUSY  out  1  sequence in progress
DONE  out  1  all LUT_SIZE words acknowledged
ERROR  out  1  a word exhausted its retries
CUR_INDEX  out  4  table index currently or last processed
Interface: one clock (CLOCK); reset RESET_N is asynchronous, active-low.

Behaviour:
- Reset values: I2C_CTRL_CLK=0, GO=0, I2C_DATA=0, BUSY=0, DONE=0, ERROR=0, CUR_INDEX=0; divider, retry count, timeout cleared; state SETUP (auto-start).
- Divider: counter 0..CLK_FREQ/(2*I2C_FREQ)-1 (1249 default); at terminal count toggle I2C_CTRL_CLK and wrap. tick = one-CLOCK pulse on the cycle I2C_CTRL_CLK goes 0->1. All FSM state changes, except reset and START capture, occur only on tick.
- FSM:
  SETUP: GO=0, I2C_DATA=LUT[CUR_INDEX], BUSY=1; stay 2 ticks (controller reaches count 0, END=0) -> RUN.
  RUN: GO=1; record END==0 seen; on tick with END==1 after a low was seen -> CHECK. Timeout counter counts ticks; at 64 ticks -> CHECK flagged as failure.
  CHECK: GO=0. Pass if ACK==3'b000 and no timeout: retry=0; if CUR_INDEX==LUT_SIZE-1 -> DONE else CUR_INDEX+1 -> SETUP. Fail: if retry<MAX_RETRY, retry+1 -> SETUP with the same index; else -> ERROR.
  DONE: DONE=1, BUSY=0, GO=0. ERROR: ERROR=1, BUSY=0, GO=0, CUR_INDEX frozen on the failing word.
- START: latched on any CLOCK edge; in DONE/ERROR clears DONE/ERROR/retry, CUR_INDEX=0 -> SETUP at next tick; ignored while BUSY.
- I2C_DATA changes only in SETUP (GO=0); stable for the whole RUN.
- Reset mid-transfer: GO drops to 0 asynchronously; after release, the sequence restarts at index 0.
- LUT contents (reg<<9|data as 16 bits): 1E00 reset, 001A, 021A line in L/R, 047B, 067B headphone L/R, 08F8 analog path, 0A06 digital path, 0C00 power on, 0E01 format, 1002 sample rate, 1201 active.

Decomposition:
- Package i2c_cfg_pkg: state enum (SETUP, RUN, CHECK, DONE, ERROR), TIMEOUT_TICKS=64, ACK_ALL_OK=3'b000, default SLAVE_ADDR.
- Sub-module codec_reg_rom: combinational index (4 bits) -> 16-bit reg/data; out-of-range index returns 16'h0000.

Test Plan:
- Reset release, controller model always ACK -> 11 transfers; I2C_DATA sequence 341E00, 34001A ... 341201; DONE=1, CUR_INDEX=10, ERROR=0.
- Divider check -> I2C_CTRL_CLK period exactly 2500 CLOCK cycles, 50% duty.
- Single NACK (ACK=3'b010) on index 3 -> index 3 resent once with identical I2C_DATA 34047B, then sequence completes with DONE=1.
- Persistent NACK on index 5 -> 4 attempts total, ERROR=1, CUR_INDEX=5, GO=0; START pulse -> restart at index 0, full pass -> DONE.
- END held 0 by model on index 2 -> timeout after 64 ticks, retried; model recovers -> DONE.
- RESET_N asserted during RUN at index 7 -> GO=0 immediately; after release the first I2C_DATA is 341E00; START pulse while BUSY -> no effect.

Source files
------------

// File: rtl/i2c_codec_config_seq_pkg.sv
// Shared types and constants for the audio-codec I2C configuration sequencer.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    ST_SETUP,
    ST_RUN,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int unsigned TIMEOUT_TICKS      = 64;
  localparam int unsigned SETUP_TICKS        = 2;
  localparam logic [2:0]  ACK_ALL_OK         = 3'b000;
  localparam logic [7:0]  DEFAULT_SLAVE_ADDR = 8'h34;

endpackage

// File: rtl/i2c_codec_config_seq_rom.sv
// Fixed codec register table: index -> {reg[6:0], data[8:0]}; unused indices read as zero.
module codec_reg_rom (
  input  logic [3:0]  idx_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = 16'h0000;
    case (idx_i)
      4'd0:    word_o = 16'h1E00;
      4'd1:    word_o = 16'h001A;
      4'd2:    word_o = 16'h021A;
      4'd3:    word_o = 16'h047B;
      4'd4:    word_o = 16'h067B;
      4'd5:    word_o = 16'h08F8;
      4'd6:    word_o = 16'h0A06;
      4'd7:    word_o = 16'h0C00;
      4'd8:    word_o = 16'h0E01;
      4'd9:    word_o = 16'h1002;
      4'd10:   word_o = 16'h1201;
      default: word_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/i2c_codec_config_seq.sv
// Walks the codec register table through the I2C byte controller, retrying NACKed or
// stalled words, and generates the controller's divided clock.
module i2c_codec_config_seq
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned I2C_FREQ   = 20000,
  parameter int unsigned LUT_SIZE   = 11,
  parameter int unsigned MAX_RETRY  = 3,
  parameter logic [7:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        START,
  output logic        I2C_CTRL_CLK,
  output logic [23:0] I2C_DATA,
  output logic        GO,
  input  logic        END,
  input  logic [2:0]  ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [3:0]  CUR_INDEX
);

  localparam int unsigned DIV_HALF = CLK_FREQ / (2 * I2C_FREQ);
  localparam int unsigned DIV_W    = ($clog2(DIV_HALF) > 0) ? $clog2(DIV_HALF) : 1;
  localparam int unsigned TW       = $clog2(TIMEOUT_TICKS);
  localparam int unsigned RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [DIV_W-1:0] div_q;
  logic             ctrl_clk_q;
  logic             div_wrap;
  logic             tick;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             seen_low_q, seen_low_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic             start_q, start_d;
  logic [23:0]      data_q;
  logic             busy_q, done_q, err_q;
  logic [15:0]      rom_word;

  codec_reg_rom u_rom (
    .idx_i  (idx_q),
    .word_o (rom_word)
  );

  // tick marks the CLOCK edge on which the controller clock rises.
  assign div_wrap = (div_q == DIV_W'(DIV_HALF - 1));
  assign tick     = div_wrap & ~ctrl_clk_q;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q      <= '0;
      ctrl_clk_q <= 1'b0;
    end else if (div_wrap) begin
      div_q      <= '0;
      ctrl_clk_q <= ~ctrl_clk_q;
    end else begin
      div_q      <= div_q + DIV_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    tcnt_d     = tcnt_q;
    seen_low_d = seen_low_q;
    tmo_flag_d = tmo_flag_q;
    start_d    = start_q;

    if (START && (state_q == ST_DONE || state_q == ST_ERROR)) begin
      start_d = 1'b1;
    end

    if (tick) begin
      case (state_q)
        ST_SETUP: begin
          if (tcnt_q == TW'(SETUP_TICKS - 1)) begin
            state_d    = ST_RUN;
            tcnt_d     = '0;
            seen_low_d = 1'b0;
            tmo_flag_d = 1'b0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        ST_RUN: begin
          // END must be seen low first so a stale END from the previous word is not taken.
          if (END && seen_low_q) begin
            state_d = ST_CHECK;
            tcnt_d  = '0;
          end else if (tcnt_q == TW'(TIMEOUT_TICKS - 1)) begin
            state_d    = ST_CHECK;
            tcnt_d     = '0;
            tmo_flag_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
            if (!END) begin
              seen_low_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          tcnt_d = '0;
          if (ACK == ACK_ALL_OK && !tmo_flag_q) begin
            retry_d = '0;
            if (idx_q == 4'(LUT_SIZE - 1)) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = ST_SETUP;
            end
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_SETUP;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (start_q) begin
            start_d = 1'b0;
            idx_d   = '0;
            retry_d = '0;
            tcnt_d  = '0;
            state_d = ST_SETUP;
          end
        end
        default: state_d = ST_SETUP;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_SETUP;
      idx_q      <= '0;
      retry_q    <= '0;
      tcnt_q     <= '0;
      seen_low_q <= 1'b0;
      tmo_flag_q <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      tcnt_q     <= tcnt_d;
      seen_low_q <= seen_low_d;
      tmo_flag_q <= tmo_flag_d;
      start_q    <= start_d;
      busy_q     <= (state_d == ST_SETUP) || (state_d == ST_RUN) || (state_d == ST_CHECK);
      done_q     <= (state_d == ST_DONE);
      err_q      <= (state_d == ST_ERROR);
    end
  end

  // Word is only reloaded while GO is low, so it is frozen for the whole transfer.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      data_q <= '0;
    end else if (state_q == ST_SETUP) begin
      data_q <= {SLAVE_ADDR, rom_word};
    end
  end

  assign I2C_CTRL_CLK = ctrl_clk_q;
  assign I2C_DATA     = data_q;
  assign GO           = (state_q == ST_RUN);
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign ERROR        = err_q;
  assign CUR_INDEX    = idx_q;

endmodule
